// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback stage: FSM encoding, result
// record and the retired-write counter increment.
package wb_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int NREG_DEF       = 8;
    localparam int LD_TIMEOUT_DEF = 15;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_WAIT_LD = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic [$clog2(NREG_DEF)-1:0] rd;
        logic [XLEN_DEF-1:0]         res;
        logic                        is_ld;
    } ex_result_t;

    function automatic logic [15:0] cnt_inc(input logic [15:0] c);
        return c + 16'd1;
    endfunction

endpackage

// File: rtl/wb_if.sv
// Bus bundle between execute, load response, decode read ports and the
// writeback stage. The stage uses the slave view, its environment the master.
interface wb_if #(
    parameter  int XLEN = 32,
    parameter  int NREG = 8,
    localparam int AW   = $clog2(NREG)
);
    logic            ex_valid;
    logic            ex_ready;
    logic [AW-1:0]   ex_rd;
    logic [XLEN-1:0] ex_res;
    logic            ex_is_ld;
    logic            ld_rsp_valid;
    logic [XLEN-1:0] ld_rsp_data;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            wb_valid;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_wbv;
    logic [15:0]     wb_count;
    logic            ld_err;

    modport slave (
        input  ex_valid, ex_rd, ex_res, ex_is_ld, ld_rsp_valid, ld_rsp_data,
               rs1_addr, rs2_addr,
        output ex_ready, rs1_data, rs2_data, wb_valid, wb_rd, wb_wbv,
               wb_count, ld_err
    );

    modport master (
        output ex_valid, ex_rd, ex_res, ex_is_ld, ld_rsp_valid, ld_rsp_data,
               rs1_addr, rs2_addr,
        input  ex_ready, rs1_data, rs2_data, wb_valid, wb_rd, wb_wbv,
               wb_count, ld_err
    );
endinterface

// File: rtl/wb_regfile.sv
// Architectural register file: one write port, two combinational read ports
// that forward the write landing at the coming edge. Register 0 reads as zero.
module wb_regfile #(
    parameter  int XLEN = 32,
    parameter  int NREG = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [AW-1:0]   raddr1_i,
    input  logic [AW-1:0]   raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);

    logic [XLEN-1:0] mem_q [NREG];

    // Storage array; entry 0 is never written so it holds its reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port 1 with write-forwarding.
    always_comb begin
        if (raddr1_i == '0) begin
            rdata1_o = '0;
        end else if (we_i && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end else begin
            rdata1_o = mem_q[raddr1_i];
        end
    end

    // Read port 2 with write-forwarding.
    always_comb begin
        if (raddr2_i == '0) begin
            rdata2_o = '0;
        end else if (we_i && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end else begin
            rdata2_o = mem_q[raddr2_i];
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results immediately and load results when the
// response arrives, abandoning loads that exceed the response timeout.
module wb_stage
    import wb_pkg::*;
#(
    parameter  int XLEN       = XLEN_DEF,
    parameter  int NREG       = NREG_DEF,
    parameter  int LD_TIMEOUT = LD_TIMEOUT_DEF,
    localparam int AW         = $clog2(NREG)
) (
    input logic clk,
    input logic rst_n,
    wb_if.slave bus
);

    localparam int TW = $clog2(LD_TIMEOUT + 1);

    wb_state_e       state_q, state_d;
    logic [AW-1:0]   pend_rd_q, pend_rd_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            wb_valid_q, wb_valid_d;
    logic [AW-1:0]   wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_wbv_q, wb_wbv_d;
    logic [15:0]     wb_count_q, wb_count_d;
    logic            ld_err_q, ld_err_d;

    logic            hs_s;
    logic            tmo_hit_s;
    logic            wr_s;
    logic            we_s;
    logic [AW-1:0]   wr_rd_s;
    logic [XLEN-1:0] wr_val_s;
    logic [XLEN-1:0] rd1_s;
    logic [XLEN-1:0] rd2_s;

    assign hs_s      = bus.ex_valid && (state_q == ST_IDLE);
    assign tmo_hit_s = (tmo_q == TW'(LD_TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a response takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (hs_s && bus.ex_is_ld) begin
                    state_d = ST_WAIT_LD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_LD: begin
                if (bus.ld_rsp_valid || tmo_hit_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_LD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values: write selection, pending rd, timeout, error.
    always_comb begin
        wr_s      = 1'b0;
        wr_rd_s   = '0;
        wr_val_s  = '0;
        pend_rd_d = pend_rd_q;
        tmo_d     = tmo_q;
        ld_err_d  = ld_err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.ld_rsp_valid) begin
                    ld_err_d = 1'b1;
                end else begin
                    ld_err_d = ld_err_q;
                end
                if (hs_s && bus.ex_is_ld) begin
                    pend_rd_d = bus.ex_rd;
                    tmo_d     = '0;
                end else if (hs_s) begin
                    wr_s     = 1'b1;
                    wr_rd_s  = bus.ex_rd;
                    wr_val_s = bus.ex_res;
                end else begin
                    wr_s = 1'b0;
                end
            end
            ST_WAIT_LD: begin
                if (bus.ld_rsp_valid) begin
                    wr_s     = 1'b1;
                    wr_rd_s  = pend_rd_q;
                    wr_val_s = bus.ld_rsp_data;
                end else if (tmo_hit_s) begin
                    ld_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: begin
                wr_s = 1'b0;
            end
        endcase

        we_s = wr_s && (wr_rd_s != '0);
        if (wr_s) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = wr_rd_s;
            wb_wbv_d   = (wr_rd_s == '0) ? '0 : wr_val_s;
        end else begin
            wb_valid_d = 1'b0;
            wb_rd_d    = wb_rd_q;
            wb_wbv_d   = wb_wbv_q;
        end
        if (we_s) begin
            wb_count_d = cnt_inc(wb_count_q);
        end else begin
            wb_count_d = wb_count_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_rd_q  <= '0;
            tmo_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_wbv_q   <= '0;
            wb_count_q <= 16'd0;
            ld_err_q   <= 1'b0;
        end else begin
            pend_rd_q  <= pend_rd_d;
            tmo_q      <= tmo_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_wbv_q   <= wb_wbv_d;
            wb_count_q <= wb_count_d;
            ld_err_q   <= ld_err_d;
        end
    end

    wb_regfile #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (we_s),
        .waddr_i  (wr_rd_s),
        .wdata_i  (wr_val_s),
        .raddr1_i (bus.rs1_addr),
        .raddr2_i (bus.rs2_addr),
        .rdata1_o (rd1_s),
        .rdata2_o (rd2_s)
    );

    assign bus.ex_ready = (state_q == ST_IDLE);
    assign bus.rs1_data = rd1_s;
    assign bus.rs2_data = rd2_s;
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_rd    = wb_rd_q;
    assign bus.wb_wbv   = wb_wbv_q;
    assign bus.wb_count = wb_count_q;
    assign bus.ld_err   = ld_err_q;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage directly downstream of the execute stage.
- Accepts execute results (ALU value or a load marker) over a valid/ready handshake and waits for load responses when needed.
- Writes the architectural register file and drives the registered writeback value `wb_wbv`.
- Provides two bypassed combinational read ports back to decode/execute.

Parameters:
- XLEN, 32, data width of results and registers.
- NREG, 8, number of architectural registers; register 0 is hardwired to zero.
- AW, $clog2(NREG), register address width (derived; do not override).
- LD_TIMEOUT, 15, cycles spent in WAIT_LD with no response before the load is abandoned.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  execute stage offers a result.
- ex_ready  out  1  stage can accept; equals (state == IDLE).
- ex_rd  in  AW  destination register.
- ex_res  in  XLEN  ALU result; ignored when ex_is_ld = 1.
- ex_is_ld  in  1  result is a load; data arrives later on ld_rsp_*.
- ld_rsp_valid  in  1  load data valid.
- ld_rsp_data  in  XLEN  load data.
- rs1_addr, rs2_addr  in  AW  read port addresses.
- rs1_data, rs2_data  out  XLEN  read data, bypassed.
- wb_valid  out  1  a register write happened at the last edge.
- wb_rd  out  AW  destination of the last write.
- wb_wbv  out  XLEN  value of the last write.
- wb_count  out  16  count of retired writes; wraps modulo 2^16.
- ld_err  out  1  sticky error flag.

Behaviour:
- Reset (async, rst_n = 0): state IDLE; all registers 0; wb_valid 0; wb_rd 0; wb_wbv 0; wb_count 0; ld_err 0; timeout counter 0. ex_ready is 1 after reset deassertion.
- A reset asserted during WAIT_LD discards the pending load; a later ld_rsp_valid is then treated as spurious (see IDLE).
- FSM states: IDLE, WAIT_LD.
- IDLE, handshake with ex_is_ld = 0 (ex_valid & ex_ready):
  - At the same edge, regfile[ex_rd] <= ex_res, wb_valid <= 1, wb_rd <= ex_rd, wb_wbv <= ex_res.
  - Latency from handshake to wb outputs is 1 edge.
- IDLE, handshake with ex_is_ld = 1:
  - Latch ex_rd into a pending register; go to WAIT_LD; clear the timeout counter; wb_valid <= 0.
- IDLE with no handshake: wb_valid <= 0.
- ld_rsp_valid while in IDLE is spurious: ld_err <= 1, no write.
- WAIT_LD:
  - ex_ready = 0.
  - On ld_rsp_valid: regfile[pending_rd] <= ld_rsp_data; wb_* updated as for an ALU write; return to IDLE. ex_ready is 1 in the following cycle.
  - Otherwise the timeout counter increments. When it reaches LD_TIMEOUT - 1 with still no response: ld_err <= 1, no write, wb_valid <= 0, return to IDLE.
  - Response and timeout in the same cycle: the response wins.
- Writes to rd = 0:
  - wb_valid/wb_rd/wb_wbv update normally, but wb_wbv is forced to 0.
  - The regfile is not written and wb_count does not increment.
  - Otherwise wb_count increments once per regfile write.
- ld_err is sticky; only reset clears it.
- Read ports:
  - Address 0 returns 0.
  - If a regfile write to the same nonzero address occurs at the coming edge, the port returns the incoming write data (bypass).
  - Otherwise the port returns the stored value.
  - Both ports may bypass simultaneously.
- Width: no arithmetic on data; wb_count is a 16-bit wrapping increment.

Decomposition:
- Package wb_pkg: state enum (IDLE, WAIT_LD), default XLEN/NREG constants, and an ex_result struct {rd, res, is_ld}.
- One sub-module, wb_regfile:
  - NREG x XLEN array with async reset and one write port.
  - Ignores writes to address 0.
  - Two combinational read ports with write-bypass.
- wb_stage holds the FSM, pending rd, timeout counter, wb output registers, wb_count and ld_err.

Test Plan:
- ALU write: rd=3, res=0xDEADBEEF, handshake → next cycle wb_valid=1, wb_rd=3, wb_wbv=0xDEADBEEF, wb_count=1; rs1_addr=3 then reads 0xDEADBEEF.
- Bypass: in the handshake cycle for rd=5, res=0x55, rs1_addr=rs2_addr=5 → both read ports return 0x55 combinationally.
- Load: is_ld with rd=2 → ex_ready=0; ld_rsp_valid with 0x1234 after 4 cycles → wb_wbv=0x1234, regfile[2]=0x1234, ex_ready=1 the following cycle.
- Timeout: load accepted, no response → exactly LD_TIMEOUT cycles later ld_err=1, state IDLE, no write, wb_count unchanged; ld_err stays 1 until rst_n is asserted.
- rd=0 write of 0xFF → wb_wbv=0, rs1_addr=0 reads 0, wb_count unchanged; spurious ld_rsp_valid in IDLE → ld_err=1.
- Reset mid-load: rst_n low during WAIT_LD → all outputs 0, IDLE; a subsequent ld_rsp_valid sets ld_err and causes no write. Separately, 65536 writes wrap wb_count to 0.
